// File: rtl/state_seq_ctrl.sv
// Sequencing controller that steps a 3-bit state {a,b,c} through an external next-state datapath.
// Optional self-loop stall detection in RUN is enabled by defining SEQ_CTRL_STALL_DETECT_EN.
module state_seq_ctrl #(
    parameter int          CNT_W     = 8,
    parameter logic [2:0]  RST_STATE = 3'b001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             halt,
    input  logic [2:0]       ns_in,
    input  logic             y_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] y_cnt,
    output logic             stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    state_e           state_q, state_d;
    logic [2:0]       abc_q, abc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] ycnt_q, ycnt_d;
    logic             advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            abc_q   <= RST_STATE;
            rem_q   <= '0;
            ycnt_q  <= '0;
        end else begin
            state_q <= state_d;
            abc_q   <= abc_d;
            rem_q   <= rem_d;
            ycnt_q  <= ycnt_d;
        end
    end

`ifdef SEQ_CTRL_STALL_DETECT_EN
    logic stall_q, stall_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        abc_d   = abc_q;
        rem_d   = rem_q;
        ycnt_d  = ycnt_q;
        advance = 1'b0;
`ifdef SEQ_CTRL_STALL_DETECT_EN
        stall_d = stall_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        OP_NOP: begin
                            state_d = S_IDLE;
                        end
                        OP_STEP: begin
                            state_d = S_STEP;
                        end
                        OP_RUN: begin
                            ycnt_d = '0;
`ifdef SEQ_CTRL_STALL_DETECT_EN
                            stall_d = 1'b0;
`endif
                            if (cmd_arg == '0) begin
                                state_d = S_DONE;
                            end else begin
                                rem_d   = cmd_arg;
                                state_d = S_RUN;
                            end
                        end
                        OP_LOAD: begin
                            abc_d   = cmd_arg[2:0];
                            state_d = S_DONE;
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end
            S_STEP: begin
                advance = 1'b1;
                state_d = S_DONE;
            end
            S_RUN: begin
                if (halt) begin
                    rem_d   = '0;
                    state_d = S_DONE;
                end else begin
                    advance = 1'b1;
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
`ifdef SEQ_CTRL_STALL_DETECT_EN
                    // A self-loop would spin uselessly; take the advance, flag it and finish.
                    if (ns_in == abc_q) begin
                        stall_d = 1'b1;
                        rem_d   = '0;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            abc_d = ns_in;
            if (y_in && (ycnt_q != '1)) begin
                ycnt_d = ycnt_q + CNT_W'(1);
            end
        end
    end

    assign a         = abc_q[2];
    assign b         = abc_q[1];
    assign c         = abc_q[0];
    assign y_cnt     = ycnt_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_STEP) || (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_state_seq_ctrl.sv
// Randomized and directed bench for state_seq_ctrl against a cycle-level behavioural model.
// Follows SEQ_CTRL_STALL_DETECT_EN the same way the design does.
module tb_state_seq_ctrl;

    localparam int CNT_W = 8;
    localparam int YMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_arg;
    logic             halt;
    logic [2:0]       ns_in;
    logic             y_in;
    logic             a, b, c;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] y_cnt;
    logic             stall;

    int assertCount = 0;
    int failCount   = 0;
    bit randHaltEn  = 0;

    // Datapath: 001->101->000->011->010->011, 100 loops on itself.
    logic [2:0] nsTable [8];
    logic [7:0] yMask;

    initial begin
        nsTable[0] = 3'b011;
        nsTable[1] = 3'b101;
        nsTable[2] = 3'b011;
        nsTable[3] = 3'b010;
        nsTable[4] = 3'b100;
        nsTable[5] = 3'b000;
        nsTable[6] = 3'b001;
        nsTable[7] = 3'b110;
    end

    assign ns_in = nsTable[{a, b, c}];
    assign y_in  = yMask[{a, b, c}];

    state_seq_ctrl #(.CNT_W(CNT_W), .RST_STATE(3'b001)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .halt      (halt),
        .ns_in     (ns_in),
        .y_in      (y_in),
        .a         (a),
        .b         (b),
        .c         (c),
        .busy      (busy),
        .done      (done),
        .y_cnt     (y_cnt),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outstanding advances, a pending done pulse, the state, the y count and the stall flag.
    bit         mValid = 0;
    int         mSteps = 0;
    bit         mIsRun = 0;
    bit         mDone  = 0;
    logic [2:0] mSt    = 3'b001;
    int         mY     = 0;
    bit         mStall = 0;

    always @(posedge clk) begin : model
        int         steps;
        bit         dn;
        bit         isRun;
        logic [2:0] st;
        logic [2:0] nxt;
        int         yc;
        bit         stl;
        steps = mSteps;
        dn    = mDone;
        isRun = mIsRun;
        st    = mSt;
        yc    = mY;
        stl   = mStall;
        if (reset) begin
            steps = 0;
            dn    = 0;
            isRun = 0;
            st    = 3'b001;
            yc    = 0;
            stl   = 0;
            mValid <= 1'b1;
        end else if (dn) begin
            dn = 0;
        end else if (steps > 0) begin
            if (isRun && halt) begin
                steps = 0;
                dn    = 1;
            end else begin
                nxt = nsTable[st];
                if (yMask[st] && yc < YMAX) yc++;
`ifdef SEQ_CTRL_STALL_DETECT_EN
                if (isRun && nxt == st) begin
                    stl   = 1;
                    steps = 1;
                end
`endif
                st = nxt;
                steps--;
                if (steps == 0) dn = 1;
            end
        end else if (cmd_valid) begin
            case (cmd_op)
                2'b01: begin
                    steps = 1;
                    isRun = 0;
                end
                2'b10: begin
                    yc    = 0;
                    stl   = 0;
                    isRun = 1;
                    steps = int'(cmd_arg);
                    if (steps == 0) dn = 1;
                end
                2'b11: begin
                    st = cmd_arg[2:0];
                    dn = 1;
                end
                default: ;
            endcase
        end
        mSteps <= steps;
        mDone  <= dn;
        mIsRun <= isRun;
        mSt    <= st;
        mY     <= yc;
        mStall <= stl;
    end

    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("state",     32'({a, b, c}), 32'(mSt));
            checkOutput("cmd_ready", 32'(cmd_ready), 32'(mSteps == 0 && !mDone));
            checkOutput("busy",      32'(busy),      32'(mSteps > 0));
            checkOutput("done",      32'(done),      32'(mDone));
            checkOutput("y_cnt",     32'(y_cnt),     32'(mY));
            checkOutput("stall",     32'(stall),     32'(mStall));
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #2;
        halt = randHaltEn ? ($urandom_range(0, 5) == 0) : 1'b0;
    endtask

    // Offers a command and returns in the first cycle after its acceptance edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [CNT_W-1:0] arg);
        bit accepted = 0;
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready) begin
                accepted = 1;
                break;
            end
            stepCycle();
        end
        checkOutput("accept within budget", 32'(accepted), 32'd1);
        stepCycle();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_arg   = CNT_W'($urandom);
    endtask

    task automatic waitDone(input int limit, output int lat);
        lat = 1;
        while (!done && lat < limit) begin
            stepCycle();
            lat++;
        end
        checkOutput("done within budget", 32'(done), 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int         lat;
        logic [2:0] seq [6];
        bit         sawDone;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = '0;
        halt      = 1'b0;
        yMask     = 8'b0000_0001;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        repeat (3) stepCycle();
        checkOutput("reset state",     32'({a, b, c}), 32'b001);
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset busy",      32'(busy),      32'd0);
        checkOutput("reset y_cnt",     32'(y_cnt),     32'd0);
        checkOutput("reset stall",     32'(stall),     32'd0);

        applyStimulus(2'b11, CNT_W'(1));
        waitDone(10, lat);
        checkOutput("load latency", 32'(lat), 32'd1);
        stepCycle();
        applyStimulus(2'b01, '0);
        waitDone(10, lat);
        checkOutput("step latency", 32'(lat), 32'd2);
        checkOutput("step state",   32'({a, b, c}), 32'b101);
        stepCycle();
        checkOutput("step single done", 32'(done), 32'd0);

        applyStimulus(2'b11, CNT_W'(1));
        waitDone(10, lat);
        applyStimulus(2'b10, CNT_W'(4));
        for (int i = 1; i <= 5; i++) begin
            seq[i] = {a, b, c};
            if (i == 4) checkOutput("run4 no early done", 32'(done), 32'd0);
            if (i < 5) stepCycle();
        end
        checkOutput("run4 seq1", 32'(seq[2]), 32'b101);
        checkOutput("run4 seq2", 32'(seq[3]), 32'b000);
        checkOutput("run4 seq3", 32'(seq[4]), 32'b011);
        checkOutput("run4 seq4", 32'(seq[5]), 32'b010);
        checkOutput("run4 done at 5", 32'(done), 32'd1);
        checkOutput("run4 y_cnt", 32'(y_cnt), 32'd1);

        applyStimulus(2'b10, '0);
        waitDone(10, lat);
        checkOutput("run0 latency", 32'(lat >= 1 && lat <= 2), 32'd1);
        checkOutput("run0 state",   32'({a, b, c}), 32'b010);
        checkOutput("run0 y_cnt",   32'(y_cnt), 32'd0);

        applyStimulus(2'b11, CNT_W'(1));
        waitDone(10, lat);
        applyStimulus(2'b10, CNT_W'(10));
        stepCycle();
        stepCycle();
        halt = 1'b1;
        stepCycle();
        checkOutput("halt done",  32'(done), 32'd1);
        checkOutput("halt busy",  32'(busy), 32'd0);
        checkOutput("halt state", 32'({a, b, c}), 32'b000);
        stepCycle();
        checkOutput("halt back to idle", 32'(cmd_ready), 32'd1);

        applyStimulus(2'b11, CNT_W'(1));
        waitDone(10, lat);
        applyStimulus(2'b10, CNT_W'(6));
        stepCycle();
        stepCycle();
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("midrun reset state", 32'({a, b, c}), 32'b001);
        checkOutput("midrun reset ready", 32'(cmd_ready), 32'd1);
        sawDone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) sawDone = 1;
            stepCycle();
        end
        checkOutput("midrun reset no done", 32'(sawDone), 32'd0);

        applyStimulus(2'b11, CNT_W'(4));
        waitDone(10, lat);
        applyStimulus(2'b10, CNT_W'(5));
        waitDone(20, lat);
`ifdef SEQ_CTRL_STALL_DETECT_EN
        checkOutput("selfloop latency", 32'(lat),   32'd2);
        checkOutput("selfloop stall",   32'(stall), 32'd1);
`else
        checkOutput("selfloop latency", 32'(lat),   32'd6);
        checkOutput("selfloop stall",   32'(stall), 32'd0);
`endif
        checkOutput("selfloop state", 32'({a, b, c}), 32'b100);
        applyStimulus(2'b01, '0);
        waitDone(10, lat);
        applyStimulus(2'b10, '0);
        checkOutput("stall cleared by run", 32'(stall), 32'd0);
        waitDone(10, lat);

        yMask = 8'hFF;
        applyStimulus(2'b11, CNT_W'(1));
        waitDone(10, lat);
        applyStimulus(2'b10, CNT_W'(255));
        waitDone(300, lat);
        checkOutput("sat run y_cnt", 32'(y_cnt), 32'd255);
        applyStimulus(2'b01, '0);
        waitDone(10, lat);
        checkOutput("sat step y_cnt", 32'(y_cnt), 32'd255);
        applyStimulus(2'b11, CNT_W'(1));
        waitDone(10, lat);
        checkOutput("load keeps y_cnt", 32'(y_cnt), 32'd255);
        applyStimulus(2'b10, CNT_W'(3));
        waitDone(10, lat);
        checkOutput("run3 y_cnt", 32'(y_cnt), 32'd3);

        randHaltEn = 1;
        for (int n = 0; n < 300; n++) begin
            yMask = 8'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                stepCycle();
                reset = 1'b0;
            end
            applyStimulus(2'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 12)));
            repeat ($urandom_range(0, 3)) stepCycle();
        end
        randHaltEn = 0;
        repeat (20) stepCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
